// File: rtl/ac_motor_run_sequencer_pkg.sv
// Shared definitions for the AC motor run/stop sequencer: state codes and
// gate-vector bit positions used wherever shoot-through is detected.
package ac_motor_run_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BOOT      = 3'd1,
    ST_RAMP_UP   = 3'd2,
    ST_RUN       = 3'd3,
    ST_RAMP_DOWN = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  // Gate vector is {s1_high, s1_low, s2_high, s2_low, s3_high, s3_low}.
  localparam int S1_HIGH = 5;
  localparam int S1_LOW  = 4;
  localparam int S2_HIGH = 3;
  localparam int S2_LOW  = 2;
  localparam int S3_HIGH = 1;
  localparam int S3_LOW  = 0;

  function automatic logic gateOverlap(input logic [5:0] g);
    return (g[S1_HIGH] & g[S1_LOW]) |
           (g[S2_HIGH] & g[S2_LOW]) |
           (g[S3_HIGH] & g[S3_LOW]);
  endfunction

endpackage

// File: rtl/ac_motor_run_sequencer_ramp_limiter.sv
// Rate limiter: every RAMP_DIV enabled cycles the value moves toward the
// target by at most RAMP_STEP, clamped so it never overshoots or wraps.
module ac_motor_ramp_limiter #(
  parameter int PW        = 12,
  parameter int RAMP_DIV  = 1000,
  parameter int RAMP_STEP = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          zero,
  input  logic          step_en,
  input  logic [PW-1:0] target,
  output logic [PW-1:0] value
);

  localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);
  localparam logic [PW:0]   STEP_W   = (PW + 1)'(RAMP_STEP);

  logic [DW-1:0] div_q;
  logic [PW-1:0] value_q;
  logic [PW-1:0] stepped;
  logic [PW:0]   upSum;
  logic [PW:0]   dnDiff;

  // The extra top bit catches carry/borrow so the step clamps at the target.
  always_comb begin
    upSum   = {1'b0, value_q} + STEP_W;
    dnDiff  = {1'b0, value_q} - STEP_W;
    stepped = value_q;
    if (target > value_q) begin
      stepped = (upSum > {1'b0, target}) ? target : upSum[PW-1:0];
    end else if (target < value_q) begin
      stepped = (dnDiff[PW] || (dnDiff[PW-1:0] < target)) ? target : dnDiff[PW-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      value_q <= '0;
    end else begin
      if (zero) begin
        value_q <= '0;
      end else if (step_en && !clr && (div_q == DIV_LAST)) begin
        value_q <= stepped;
      end
      if (clr || zero) begin
        div_q <= '0;
      end else if (step_en) begin
        div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end
    end
  end

  assign value = value_q;

endmodule

// File: rtl/ac_motor_run_sequencer.sv
// Run/stop sequencer for the inverter chain: bootstrap hold, rate-limited
// power ramps, controlled stop and a latched shoot-through fault.
module ac_motor_run_sequencer
  import ac_motor_run_sequencer_pkg::*;
#(
  parameter int PW           = 12,
  parameter int RAMP_DIV     = 1000,
  parameter int RAMP_STEP    = 1,
  parameter int BOOT_CYCLES  = 2000,
  parameter int FAULT_FILTER = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          fault_clear,
  input  logic [PW-1:0] target_power,
  input  logic [5:0]    gate,
  output logic [PW-1:0] power_out,
  output logic          enable_out,
  output logic          running,
  output logic          fault,
  output logic [2:0]    state
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int SW = $clog2(FAULT_FILTER + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [SW-1:0] SHOOT_MAX = SW'(FAULT_FILTER);

  state_e        state_q, state_d;
  logic [BW-1:0] bootCnt_q;
  logic [SW-1:0] shootCnt_q, shootCnt_d;
  logic          enable_q, running_q, fault_q;
  logic          go, trip;
  logic          rampClr, rampZero, rampStep;
  logic [PW-1:0] rampTarget, powerVal;

  // Trip outranks every request; stop (or start dropping) outranks start.
  always_comb begin
    go         = start & ~stop;
    shootCnt_d = '0;
    if (gateOverlap(gate) && enable_q) begin
      shootCnt_d = (shootCnt_q == SHOOT_MAX) ? SHOOT_MAX : shootCnt_q + 1'b1;
    end
    trip    = (shootCnt_d == SHOOT_MAX);
    state_d = state_q;
    if (trip) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE:      if (go) state_d = ST_BOOT;
        ST_BOOT:      if (!go) state_d = ST_IDLE;
                      else if (bootCnt_q == BOOT_LAST) state_d = ST_RAMP_UP;
        ST_RAMP_UP:   if (!go) state_d = ST_RAMP_DOWN;
                      else if (powerVal == target_power) state_d = ST_RUN;
        ST_RUN:       if (!go) state_d = ST_RAMP_DOWN;
        ST_RAMP_DOWN: if (go) state_d = ST_RAMP_UP;
                      else if (powerVal == '0) state_d = ST_IDLE;
        ST_FAULT:     if (fault_clear && !start) state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  assign rampClr    = (state_d != state_q);
  assign rampZero   = (state_d == ST_IDLE) || (state_d == ST_BOOT) || (state_d == ST_FAULT);
  assign rampStep   = (state_q == ST_RAMP_UP) || (state_q == ST_RUN) || (state_q == ST_RAMP_DOWN);
  assign rampTarget = (state_q == ST_RAMP_DOWN) ? '0 : target_power;

  ac_motor_ramp_limiter #(
    .PW        (PW),
    .RAMP_DIV  (RAMP_DIV),
    .RAMP_STEP (RAMP_STEP)
  ) u_ramp (
    .clk     (clk),
    .reset   (reset),
    .clr     (rampClr),
    .zero    (rampZero),
    .step_en (rampStep),
    .target  (rampTarget),
    .value   (powerVal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bootCnt_q  <= '0;
      shootCnt_q <= '0;
      enable_q   <= 1'b0;
      running_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shootCnt_q <= shootCnt_d;
      if (state_d != state_q) begin
        bootCnt_q <= '0;
      end else if (state_q == ST_BOOT) begin
        bootCnt_q <= bootCnt_q + 1'b1;
      end
      enable_q  <= (state_d == ST_BOOT) || (state_d == ST_RAMP_UP) ||
                   (state_d == ST_RUN) || (state_d == ST_RAMP_DOWN);
      running_q <= (state_d == ST_RUN);
      fault_q   <= (state_d == ST_FAULT);
    end
  end

  assign power_out  = powerVal;
  assign enable_out = enable_q;
  assign running    = running_q;
  assign fault      = fault_q;
  assign state      = state_q;

endmodule

// File: tb/tb_ac_motor_run_sequencer.sv
// Bench for the run sequencer: directed walk through start-up, tracking, stop,
// fault and reset, then random traffic, all against a cycle model.
module tb_ac_motor_run_sequencer;
  import ac_motor_run_sequencer_pkg::*;

  localparam int PW   = 12;
  localparam int DIV  = 4;
  localparam int STEP = 10;
  localparam int BOOT = 8;
  localparam int FF   = 2;

  localparam int M_IDLE = 0, M_BOOT = 1, M_UP = 2, M_RUN = 3, M_DOWN = 4, M_FAULT = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, stop, fault_clear;
  logic [PW-1:0] target_power;
  logic [5:0]    gate;
  logic [PW-1:0] power_out;
  logic          enable_out, running, fault;
  logic [2:0]    state;

  int total = 0;
  int bad   = 0;
  int mState, mPower, mEn, mRun, mFault, mAge, mShoot;

  ac_motor_run_sequencer #(
    .PW(PW), .RAMP_DIV(DIV), .RAMP_STEP(STEP), .BOOT_CYCLES(BOOT), .FAULT_FILTER(FF)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .fault_clear(fault_clear),
    .target_power(target_power), .gate(gate), .power_out(power_out),
    .enable_out(enable_out), .running(running), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit tbOverlap(input logic [5:0] g);
    return (g[S1_HIGH] && g[S1_LOW]) || (g[S2_HIGH] && g[S2_LOW]) || (g[S3_HIGH] && g[S3_LOW]);
  endfunction

  function automatic int moveToward(input int p, input int t);
    if (t > p) return p + ((t - p < STEP) ? t - p : STEP);
    if (t < p) return p - ((p - t < STEP) ? p - t : STEP);
    return p;
  endfunction

  task automatic modelReset();
    mState = M_IDLE; mPower = 0; mEn = 0; mRun = 0; mFault = 0; mAge = 0; mShoot = 0;
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".state"}, 32'(state), mState);
    check({tag, ".power"}, 32'(power_out), mPower);
    check({tag, ".enable"}, 32'(enable_out), mEn);
    check({tag, ".running"}, 32'(running), mRun);
    check({tag, ".fault"}, 32'(fault), mFault);
  endtask

  // One clock: predict from the inputs now applied, clock, then compare.
  task automatic tick(input string tag);
    int ns, np, nShoot;
    bit go, trip;
    go     = start && !stop;
    nShoot = (tbOverlap(gate) && mEn != 0) ? ((mShoot + 1 > FF) ? FF : mShoot + 1) : 0;
    trip   = (nShoot >= FF);
    ns     = mState;
    if (trip) ns = M_FAULT;
    else case (mState)
      M_IDLE:  if (go) ns = M_BOOT;
      M_BOOT:  if (!go) ns = M_IDLE; else if (mAge == BOOT - 1) ns = M_UP;
      M_UP:    if (!go) ns = M_DOWN; else if (mPower == int'(target_power)) ns = M_RUN;
      M_RUN:   if (!go) ns = M_DOWN;
      M_DOWN:  if (go) ns = M_UP; else if (mPower == 0) ns = M_IDLE;
      default: if (fault_clear && !start) ns = M_IDLE;
    endcase
    np = mPower;
    if (ns == M_IDLE || ns == M_BOOT || ns == M_FAULT) np = 0;
    else if (ns == mState && (mAge % DIV) == DIV - 1)
      np = moveToward(mPower, (mState == M_DOWN) ? 0 : int'(target_power));
    @(posedge clk);
    #1;
    mAge   = (ns != mState) ? 0 : mAge + 1;
    mState = ns;
    mPower = np;
    mShoot = nShoot;
    mEn    = (ns >= M_BOOT && ns <= M_DOWN) ? 1 : 0;
    mRun   = (ns == M_RUN) ? 1 : 0;
    mFault = (ns == M_FAULT) ? 1 : 0;
    checkAll(tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; fault_clear = 1'b0;
    target_power = '0; gate = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.state", 32'(state), 0);
    check("reset.power", 32'(power_out), 0);
    check("reset.enable", 32'(enable_out), 0);
    check("reset.running", 32'(running), 0);
    check("reset.fault", 32'(fault), 0);
    reset = 1'b0;
    modelReset();

    // Start-up: boot hold then ramp to 100.
    start = 1'b1; target_power = 12'd100;
    tick("boot");
    check("boot_enable_rise", 32'(enable_out), 1);
    for (int i = 0; i < 150 && state !== 3'd3; i++) tick("rampup");
    check("reach_run.state", 32'(state), 3);
    check("reach_run.power", 32'(power_out), 100);
    check("reach_run.running", 32'(running), 1);

    // Track a lower target while running.
    target_power = 12'd35;
    for (int i = 0; i < 100 && power_out !== 12'd35; i++) tick("track");
    tick("track_hold");
    check("track.power", 32'(power_out), 35);
    check("track.state", 32'(state), 3);

    // Controlled stop.
    stop = 1'b1;
    for (int i = 0; i < 100 && state !== 3'd0; i++) tick("rampdown");
    check("stop.state", 32'(state), 0);
    check("stop.enable", 32'(enable_out), 0);

    // Shoot-through filter: a single overlap cycle is tolerated, two trip.
    stop = 1'b0; target_power = 12'd50;
    for (int i = 0; i < 50 && state !== 3'd2; i++) tick("to_rampup");
    gate = 6'b110000; tick("glitch1");
    gate = 6'b000000; tick("glitch1_clear");
    check("no_trip.fault", 32'(fault), 0);
    gate = 6'b110000; tick("shoot1");
    tick("shoot2");
    gate = 6'b000000;
    check("trip.state", 32'(state), 5);
    check("trip.fault", 32'(fault), 1);
    check("trip.enable", 32'(enable_out), 0);
    check("trip.power", 32'(power_out), 0);

    // Fault clear is ignored while start is held.
    fault_clear = 1'b1; start = 1'b1;
    tick("clear_ignored");
    check("clear_ignored.state", 32'(state), 5);
    start = 1'b0;
    tick("clear_ok");
    fault_clear = 1'b0;
    check("clear_ok.state", 32'(state), 0);
    check("clear_ok.fault", 32'(fault), 0);

    // Async reset in the middle of a ramp.
    start = 1'b1; target_power = 12'd100;
    for (int i = 0; i < 100 && power_out !== 12'd40; i++) tick("ramp_to_40");
    check("pre_reset.power", 32'(power_out), 40);
    #3 reset = 1'b1;
    #1;
    check("async_reset.state", 32'(state), 0);
    check("async_reset.power", 32'(power_out), 0);
    check("async_reset.enable", 32'(enable_out), 0);
    check("async_reset.running", 32'(running), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    modelReset();
    stop = 1'b1;
    tick("start_and_stop");
    tick("start_and_stop2");
    check("start_stop.state", 32'(state), 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      start       = ($urandom_range(0, 15) != 0);
      stop        = ($urandom_range(0, 31) == 0);
      fault_clear = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) target_power = PW'($urandom_range(0, 150));
      if ($urandom_range(0, 19) == 0) begin
        gate = 6'b000000;
        case ($urandom_range(0, 2))
          0: gate[S1_HIGH+:0+1] = 1'b1;
          1: gate[S2_HIGH+:0+1] = 1'b1;
          default: gate[S3_HIGH+:0+1] = 1'b1;
        endcase
        gate = gate | 6'b010101 & {3{gate[S1_HIGH] ? 2'b00 : 2'b00}};
        if (gate[S1_HIGH]) gate[S1_LOW] = 1'b1;
        if (gate[S2_HIGH]) gate[S2_LOW] = 1'b1;
        if (gate[S3_HIGH]) gate[S3_LOW] = 1'b1;
      end else begin
        for (int p = 0; p < 3; p++) begin
          logic [1:0] pair;
          pair = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01);
          gate[2*p +: 2] = pair;
        end
      end
      tick("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
